grad_dac_dispatch: RTL and testbench

Buffers 32-bit gradient DAC command words from the gradient BRAM core and feeds them one at a time to the GPA-FHDO SPI serialiser (`gpa_fhdo_iface`). It sits directly upstream of that serialiser. It converts a streaming valid/ready write side into the serialiser's one-cycle `valid_i` pulse and `busy_o` handshake. It also times out lost handshakes and, optionally, expands broadcast words into per-channel transfers.

---
 rtl/grad_pkg.sv | 28 ++
 rtl/grad_sync_fifo.sv | 61 ++++++
 rtl/grad_dac_dispatch.sv | 140 ++++++++++++++
 tb/tb_grad_dac_dispatch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_pkg.sv
// Shared definitions for the gradient DAC dispatch path: command word layout
// and dispatcher FSM encoding.
package grad_pkg;

    localparam int WORD_W      = 32;
    localparam int PAYLOAD_MSB = 23;
    localparam int BCAST_BIT   = 24;
    localparam int CH_LSB      = 25;
    localparam int CH_MSB      = 26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    // Per-channel form of a broadcast word: channel field rewritten, broadcast bit cleared.
    function automatic logic [WORD_W-1:0] set_channel(input logic [WORD_W-1:0] w,
                                                      input logic [1:0]        ch);
        logic [WORD_W-1:0] r;
        r                 = w;
        r[CH_MSB:CH_LSB]  = ch;
        r[BCAST_BIT]      = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/grad_sync_fifo.sv
// Single-clock FIFO with flush and occupancy count. The head word is read
// straight from the storage registers, so a push is never visible before the next cycle.
module grad_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Flush takes priority over both a same-cycle push and pop.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/grad_dac_dispatch.sv
// Buffers gradient DAC command words and hands them one at a time to the SPI
// serialiser. Broadcast expansion is enabled with GRAD_DISPATCH_BCAST_EXPAND_EN.
module grad_dac_dispatch
    import grad_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [7:0]  BUSY_TIMEOUT = 8'd255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic              flush_i,
    output logic [WORD_W-1:0] ser_data_o,
    output logic              ser_valid_o,
    input  logic              ser_busy_i,
    input  logic              err_clr_i,
    output logic [6:0]        fifo_count_o,
    output logic              err_timeout_o,
    output logic              idle_o
);

`ifdef GRAD_DISPATCH_BCAST_EXPAND_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [1:0]        sub_q, sub_d;
    logic              bcast_q, bcast_d;
    logic [WORD_W-1:0] data_d;
    logic [WORD_W-1:0] head;
    logic [CW-1:0]     count;
    logic              pop;
    logic              err_set;
    logic              fifo_empty;
    logic              fifo_full;

    grad_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_valid_i),
        .pop     (pop),
        .flush   (flush_i),
        .wr_data (wr_data_i),
        .rd_data (head),
        .count   (count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign wr_ready_o   = !fifo_full;
    assign fifo_count_o = 7'(count);
    assign idle_o       = (state_q == ST_IDLE) && fifo_empty;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        sub_d   = sub_q;
        bcast_d = bcast_q;
        data_d  = ser_data_o;
        pop     = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !ser_busy_i && !flush_i) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                    data_d  = head;
                    sub_d   = 2'd0;
                    bcast_d = 1'b0;
                    if (BCAST_EN && head[BCAST_BIT]) begin
                        bcast_d = 1'b1;
                        data_d  = set_channel(head, 2'd0);
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                tmo_d   = BUSY_TIMEOUT;
            end
            ST_WAIT_BUSY: begin
                if (ser_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == 8'd1) begin
                    // Lost handshake: drop the word and any remaining sub-transfers.
                    err_set = 1'b1;
                    bcast_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!ser_busy_i) begin
                    if (bcast_q && (sub_q != 2'd3) && !flush_i) begin
                        sub_d   = sub_q + 2'd1;
                        data_d  = set_channel(ser_data_o, sub_q + 2'd1);
                        state_d = ST_ISSUE;
                    end else begin
                        bcast_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) bcast_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            tmo_q         <= '0;
            sub_q         <= '0;
            bcast_q       <= 1'b0;
            ser_data_o    <= '0;
            ser_valid_o   <= 1'b0;
            err_timeout_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            sub_q       <= sub_d;
            bcast_q     <= bcast_d;
            ser_data_o  <= data_d;
            ser_valid_o <= (state_d == ST_ISSUE);
            if (err_set)        err_timeout_o <= 1'b1;
            else if (err_clr_i) err_timeout_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_grad_dac_dispatch.sv
// Scoreboard bench for grad_dac_dispatch with a behavioural serialiser busy model.
module tb_grad_dac_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wr_data_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic        flush_i;
    logic [31:0] ser_data_o;
    logic        ser_valid_o;
    logic        ser_busy_i;
    logic        err_clr_i;
    logic [6:0]  fifo_count_o;
    logic        err_timeout_o;
    logic        idle_o;

    // serialiser model controls
    logic        model_busy = 1'b0;
    logic        man_en     = 1'b0;
    logic        man_busy   = 1'b0;
    bit          model_en   = 1'b1;
    bit          lose_once  = 1'b0;
    int          lo_cyc     = 1;
    int          hi_cyc     = 3;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          issue_cnt = 0;
    int          last_issue_cyc = 0;
    int          push_cyc = 0;

    assign ser_busy_i = man_en ? man_busy : model_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grad_dac_dispatch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_data_i     (wr_data_i),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .flush_i       (flush_i),
        .ser_data_o    (ser_data_o),
        .ser_valid_o   (ser_valid_o),
        .ser_busy_i    (ser_busy_i),
        .err_clr_i     (err_clr_i),
        .fifo_count_o  (fifo_count_o),
        .err_timeout_o (err_timeout_o),
        .idle_o        (idle_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input bit expect_it);
        wr_data_i  = w;
        wr_valid_i = 1'b1;
        push_cyc   = cyc;
        if (expect_it) exp_q.push_back(w);
        @(posedge clk);
        #1 wr_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k = 0;
        while (k < budget && !(exp_q.size() == 0 && idle_o && !ser_busy_i)) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    // serialiser busy model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ser_valid_o && model_en) begin
                if (lose_once) begin
                    lose_once = 1'b0;
                end else begin
                    repeat (lo_cyc) @(posedge clk);
                    #1 model_busy = 1'b1;
                    repeat (hi_cyc) @(posedge clk);
                    #1 model_busy = 1'b0;
                end
            end
        end
    end

    // issue monitor
    initial begin
        forever begin
            @(negedge clk);
            if (ser_valid_o) begin
                issue_cnt++;
                last_issue_cyc = cyc;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_unexpected: got %h want none", ser_data_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (ser_data_o !== mon_exp) begin
                        n_err++;
                        $display("FAIL issue_data: got %h want %h", ser_data_o, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        int err_cyc;
        rst_n      = 1'b0;
        wr_data_i  = '0;
        wr_valid_i = 1'b0;
        flush_i    = 1'b0;
        err_clr_i  = 1'b0;
        #3;
        chk("rst_valid", 32'(ser_valid_o), 32'd0);
        chk("rst_data",  ser_data_o, 32'd0);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        chk("rst_err",   32'(err_timeout_o), 32'd0);
        chk("rst_idle",  32'(idle_o), 32'd1);
        chk("rst_ready", 32'(wr_ready_o), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single word
        lo_cyc = 3; hi_cyc = 30;
        base = issue_cnt;
        push(32'h0200_1234, 1'b1);
        for (k = 0; k < 20 && issue_cnt == base; k++) @(negedge clk);
        chk("single_latency", 32'(last_issue_cyc), 32'(push_cyc + 2));
        for (k = 0; k < 50 && !ser_busy_i; k++) @(negedge clk);
        for (k = 0; k < 50 && ser_busy_i; k++) @(negedge clk);
        chk("single_idle_busyfall", 32'(idle_o), 32'd0);
        @(negedge clk);
        chk("single_idle_after", 32'(idle_o), 32'd1);
        wait_done("single_drain", 100);

        // fill and drain
        @(posedge clk); #1;
        man_en = 1'b1; man_busy = 1'b1;
        base = issue_cnt;
        for (int i = 0; i < 17; i++) begin
            push(32'h0000_1000 + 32'(i), i < 16);
            if (i == 15) begin
                chk("fill_ready_full", 32'(wr_ready_o), 32'd0);
                chk("fill_count16", 32'(fifo_count_o), 32'd16);
            end
        end
        chk("fill_count_after17", 32'(fifo_count_o), 32'd16);
        lo_cyc = 1; hi_cyc = 2;
        man_en = 1'b0;
        wait_done("fill_drain", 2000);
        chk("fill_issue_count", 32'(issue_cnt - base), 32'd16);

        // lost handshake
        lose_once = 1'b1;
        push(32'h0200_00A1, 1'b1);
        push(32'h0400_00B2, 1'b1);
        for (k = 0; k < 400 && !err_timeout_o; k++) @(negedge clk);
        err_cyc = cyc;
        chk("timeout_cycle", 32'(err_cyc), 32'(last_issue_cyc + 256));
        wait_done("timeout_next", 200);
        chk("timeout_sticky", 32'(err_timeout_o), 32'd1);
        @(posedge clk); #1;
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        chk("timeout_clear", 32'(err_timeout_o), 32'd0);

        // flush during WAIT_DONE
        lo_cyc = 1; hi_cyc = 20;
        base = issue_cnt;
        push(32'h0600_0F00, 1'b1);
        for (int i = 1; i < 6; i++) push(32'h0600_0F00 + 32'(i), 1'b0);
        chk("flush_busy_before", 32'(ser_busy_i), 32'd1);
        chk("flush_count_before", 32'(fifo_count_o), 32'd5);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_count_after", 32'(fifo_count_o), 32'd0);
        wait_done("flush_drain", 200);
        repeat (10) @(negedge clk);
        chk("flush_issue_count", 32'(issue_cnt - base), 32'd1);

        // broadcast
        lo_cyc = 1; hi_cyc = 3;
        base = issue_cnt;
`ifdef GRAD_DISPATCH_BCAST_EXPAND_EN
        exp_q.push_back(32'h0000_ABCD);
        exp_q.push_back(32'h0200_ABCD);
        exp_q.push_back(32'h0400_ABCD);
        exp_q.push_back(32'h0600_ABCD);
        push(32'h0100_ABCD, 1'b0);
        wait_done("bcast_drain", 300);
        chk("bcast_issue_count", 32'(issue_cnt - base), 32'd4);
`else
        push(32'h0100_ABCD, 1'b1);
        wait_done("bcast_drain", 300);
        chk("bcast_issue_count", 32'(issue_cnt - base), 32'd1);
`endif

        // asynchronous reset during WAIT_BUSY
        @(posedge clk); #1;
        model_en = 1'b0;
        man_en = 1'b1; man_busy = 1'b0;
        base = issue_cnt;
        push(32'h0200_0011, 1'b1);
        push(32'h0200_0022, 1'b0);
        for (k = 0; k < 20 && issue_cnt == base; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("arst_count_before", 32'(fifo_count_o), 32'd1);
        #2;
        rst_n = 1'b0;
        man_busy = 1'b1;
        #1;
        chk("arst_valid", 32'(ser_valid_o), 32'd0);
        chk("arst_data",  ser_data_o, 32'd0);
        chk("arst_count", 32'(fifo_count_o), 32'd0);
        chk("arst_idle",  32'(idle_o), 32'd1);
        chk("arst_ready", 32'(wr_ready_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = issue_cnt;
        push(32'h0400_0033, 1'b1);
        repeat (10) @(negedge clk);
        chk("arst_hold_while_busy", 32'(issue_cnt - base), 32'd0);
        @(posedge clk); #1;
        model_en = 1'b1;
        man_en = 1'b0;
        wait_done("arst_drain", 200);
        chk("arst_issue_after", 32'(issue_cnt - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
